// File: rtl/shiftreg_ctrl.sv
// Load/monitor sequencer for a recirculating shift register: serial MSB-first load over WIDTH cycles,
// then free rotation with phase tracking, aligned snapshots and a sticky shadow-compare error.
module shiftreg_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             sr_sw,
  output logic             sr_din,
  input  logic [WIDTH-1:0] sr_pout,
  input  logic             sr_sout,
  output logic             aligned,
  output logic             busy,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             err,
  input  logic             err_clr
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic {
    ROT  = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_q, err_d;

  logic [IW-1:0]    ser_sel;
  logic             ser_mism;
  logic             par_mism;
  logic             mism;

  // The register holds rotate-left(shadow, phase), so its MSB is shadow[WIDTH-1-phase].
  assign ser_sel  = LAST - phase_q;
  assign ser_mism = (sr_sout != shadow_q[ser_sel]);
  assign par_mism = (phase_q == '0) && (sr_pout != shadow_q);
  assign mism     = (state_q == ROT) && (ser_mism || par_mism);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    shadow_d   = shadow_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      ROT: begin
        phase_d = (phase_q == LAST) ? '0 : phase_q + IW'(1);
        if (phase_q == '0) begin
          rd_data_d  = sr_pout;
          rd_valid_d = 1'b1;
        end
        if (cmd_valid) begin
          shadow_d = cmd_data;
          idx_d    = LAST;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        idx_d = idx_q - IW'(1);
        if (idx_q == '0) begin
          state_d = ROT;
          phase_d = '0;
        end
      end
      default: state_d = ROT;
    endcase

    // A mismatch on the same edge as err_clr must still leave err set.
    err_d = (err_q && !err_clr) || mism;
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q    <= ROT;
      idx_q      <= LAST;
      phase_q    <= '0;
      shadow_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      shadow_q   <= shadow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == ROT);
  assign busy      = (state_q == LOAD);
  assign sr_sw     = (state_q == LOAD);
  assign sr_din    = (state_q == LOAD) && shadow_q[idx_q];
  assign aligned   = (state_q == ROT) && (phase_q == '0);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;

endmodule
